neuron_layer_sched: RTL and testbench
=====================================

// Module: neuron_layer_sched
// PURPOSE
//  Sequences one shared 4-input 12-bit MAC neuron (2-stage: multiply, registered, then sum)
//  to evaluate a fully-connected layer of NUM_NEURONS outputs, each with fan-in 4*CHUNKS.
//  Fetches weight chunks from a 1-cycle-latency weight memory and feeds the neuron.
//  Accumulates the per-chunk partial sums, applies optional ReLU, and streams results out
//  over a valid/ready interface. Sits between the layer activation buffer/weight ROM and the next layer.
// PARAMETERS
//  NUM_NEURONS  8  output neurons per layer (>=1)
//  CHUNKS       2  4-input chunks per neuron (>=1); fan-in = 4*CHUNKS
//  RELU_EN      1  1: clamp negative results to 0; 0: pass signed result
//  (derived) AW = $clog2(NUM_NEURONS*CHUNKS) (min 1); IW = $clog2(NUM_NEURONS) (min 1);
//            ACC_W = 12+$clog2(CHUNKS)
// PORTS
//  clk          in   1         sole clock, rising edge
//  rst          in   1         asynchronous, active-high reset
//  start        in   1         1-cycle pulse: begin layer; act_vec sampled this cycle
//  act_vec      in   20*CHUNKS signed 5b activations, chunk c lanes at [20c+5k +: 5], k=0..3
//  busy         out  1         high from cycle after accepted start until done
//  done         out  1         1-cycle pulse after last output handshake
//  err          out  1         sticky: mac_result_ready low in ACC; cleared by accepted start
//  w_rd_en      out  1         weight memory read strobe
//  w_addr       out  AW        = neuron*CHUNKS + chunk
//  w_data       in   20        signed 5b weights, lane k at [5k +: 5]; valid cycle after w_rd_en
//  mac_input_ready out 1       neuron input_ready
//  mac_in       out  20        neuron in0..in3 (lane k at [5k +: 5])
//  mac_w        out  20        neuron w0..w3 (lane k at [5k +: 5])
//  mac_result_ready in 1       neuron result_ready
//  mac_result   in   12        neuron signed result
//  out_valid    out  1         result available
//  out_ready    in   1         downstream accept
//  out_idx      out  IW        neuron index of out_data
//  out_data     out  ACC_W     signed layer output (ReLU-applied when RELU_EN)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err, w_rd_en, mac_input_ready, out_valid = 0;
//   w_addr, mac_in, mac_w, out_idx, out_data = 0; accumulator, counters, act register = 0.
//  FSM: IDLE -> FETCH -> ISSUE -> ACC -> (FETCH | OUT) ; OUT -> (FETCH | DONE) ; DONE -> IDLE.
//  IDLE: start=1 latches act_vec, clears n=0, c=0, acc=0, err; -> FETCH. Start outside IDLE is ignored.
//  FETCH: w_rd_en=1, w_addr=n*CHUNKS+c; -> ISSUE.
//  ISSUE: mac_input_ready=1, mac_w=w_data, mac_in=act chunk c; -> ACC. Outside ISSUE: mac_input_ready=0, mac_in=mac_w=0.
//  ACC: if mac_result_ready: acc += sign-extended mac_result; else set err, add nothing.
//   c<CHUNKS-1: c++, -> FETCH. Else -> OUT with out_data/out_idx registered from the final sum.
//  OUT: out_valid=1, data/idx held stable until out_ready. On handshake: acc=0, c=0;
//   n<NUM_NEURONS-1: n++, -> FETCH, else -> DONE.
//  DONE: done=1 for one cycle, busy=0 from next cycle; -> IDLE.
//  Latency: 3*CHUNKS cycles per neuron plus 1 OUT cycle when out_ready=1 (no chunk overlap).
//  Arithmetic: acc is ACC_W signed and never overflows (|mac_result| <= 4*256 = 1024 per chunk).
//   ReLU: out_data = acc<0 ? 0 : acc.
//  out_ready held low: the FSM stalls in OUT indefinitely; no weight reads occur meanwhile.
//  out_ready high outside OUT has no effect.
//  Reset mid-layer: immediate return to reset values; the partial layer is discarded, no done.
//  Edge cases: NUM_NEURONS=1 gives a single OUT then DONE.
//   CHUNKS=1 gives ACC_W=12 and every ACC goes straight to OUT.
// STRUCTURE
//  Package neuron_pkg: DATA_W=5, PROD_W=10, MAC_W=12, LANES=4, sched_state_e enum
//   {IDLE,FETCH,ISSUE,ACC,OUT,DONE}.
//  One sub-module: layer_acc_relu (ACC_W accumulator: clear/add/ReLU output register).
//  The neuron itself is instantiated outside, alongside this block.
// TESTING
//  1 NUM_NEURONS=2, CHUNKS=1, acts all 1, weights {1,2,3,4} and {-1,-1,-1,-1}, out_ready=1
//    -> outputs (0,10), (1,0) with ReLU; (1,-4) with RELU_EN=0; done 9 cycles after start.
//  2 CHUNKS=2, acts all -16, weights all -16 -> each chunk gives 1024; out_data=2048, ACC_W=13, no wrap.
//  3 out_ready low 5 cycles in OUT -> out_valid, out_idx, out_data stable; w_rd_en=0 throughout; resumes on ready.
//  4 start pulsed while busy, and act_vec changed mid-layer -> ignored; results use the act_vec latched at start.
//  5 Neuron model drops result_ready once -> err=1 sticky; layer still completes;
//    next start clears err.
//  6 rst asserted during ISSUE of neuron 1 -> all outputs 0 same cycle, no done; fresh start gives correct results.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared widths, scheduler state type and sizing helper for the layer scheduler.
package neuron_pkg;
   localparam int DATA_W = 5;
   localparam int PROD_W = 10;
   localparam int MAC_W  = 12;
   localparam int LANES  = 4;
   localparam int VEC_W  = DATA_W * LANES;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ISSUE = 3'd2,
      ACC   = 3'd3,
      OUT   = 3'd4,
      DONE  = 3'd5
   } sched_state_e;

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction
endpackage

// File: rtl/layer_acc_relu.sv
// Per-neuron partial-sum accumulator with a ReLU-applied output register
// that captures the final sum on the last chunk.
module layer_acc_relu
   import neuron_pkg::*;
#(
   parameter int ACC_W   = 13,
   parameter bit RELU_EN = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    add_i,
   input  logic                    load_i,
   input  logic signed [MAC_W-1:0] mac_result_i,
   output logic signed [ACC_W-1:0] out_data_o
);
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] out_q, out_d;
   logic signed [ACC_W-1:0] ext_res;
   logic signed [ACC_W-1:0] final_v;

   assign ext_res = ACC_W'(mac_result_i);
   assign final_v = add_i ? (acc_q + ext_res) : acc_q;

   always_comb begin
      acc_d = acc_q;
      if (clear_i) begin
         acc_d = '0;
      end else if (add_i) begin
         acc_d = final_v;
      end
   end

   // A missing result on the last chunk still loads whatever was accumulated.
   always_comb begin
      out_d = out_q;
      if (load_i) begin
         if (RELU_EN && (final_v < 0)) begin
            out_d = '0;
         end else begin
            out_d = final_v;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
         out_q <= '0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

   assign out_data_o = out_q;
endmodule

// File: rtl/neuron_layer_sched.sv
// Sequences a shared 4-lane MAC neuron over every chunk of every output neuron
// of a fully-connected layer and streams the per-neuron results out.
//
// state | meaning
// IDLE  | waiting for start; act_vec latched on start
// FETCH | weight read strobe for chunk c of neuron n
// ISSUE | weight data valid; present weights and activations to the neuron
// ACC   | accumulate neuron result (err if missing); next chunk or output
// OUT   | result valid, held until out_ready
// DONE  | one-cycle done pulse
module neuron_layer_sched
   import neuron_pkg::*;
#(
   parameter int  NUM_NEURONS = 8,
   parameter int  CHUNKS      = 2,
   parameter bit  RELU_EN     = 1'b1,
   localparam int AW          = clog2_min1(NUM_NEURONS * CHUNKS),
   localparam int IW          = clog2_min1(NUM_NEURONS),
   localparam int ACC_W       = MAC_W + $clog2(CHUNKS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [VEC_W*CHUNKS-1:0]    act_vec,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic                       w_rd_en,
   output logic [AW-1:0]              w_addr,
   input  logic [VEC_W-1:0]           w_data,
   output logic                       mac_input_ready,
   output logic [VEC_W-1:0]           mac_in,
   output logic [VEC_W-1:0]           mac_w,
   input  logic                       mac_result_ready,
   input  logic signed [MAC_W-1:0]    mac_result,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [IW-1:0]              out_idx,
   output logic signed [ACC_W-1:0]    out_data
);
   localparam int CW = clog2_min1(CHUNKS);

   sched_state_e state_q, state_d;

   logic [IW-1:0]             n_q, n_d;
   logic [CW-1:0]             c_q, c_d;
   logic [VEC_W*CHUNKS-1:0]   act_q, act_d;
   logic                      err_q, err_d;
   logic [IW-1:0]             idx_q, idx_d;

   logic last_chunk;
   logic last_neuron;
   logic acc_clear;
   logic acc_add;
   logic acc_load;

   assign last_chunk  = (c_q == CW'(CHUNKS - 1));
   assign last_neuron = (n_q == IW'(NUM_NEURONS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   state_d = ISSUE;
         ISSUE:   state_d = ACC;
         ACC:     state_d = last_chunk ? OUT : FETCH;
         OUT:     if (out_ready) state_d = last_neuron ? DONE : FETCH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy            = (state_q != IDLE);
      done            = (state_q == DONE);
      w_rd_en         = 1'b0;
      w_addr          = '0;
      mac_input_ready = 1'b0;
      mac_in          = '0;
      mac_w           = '0;
      out_valid       = (state_q == OUT);
      if (state_q == FETCH) begin
         w_rd_en = 1'b1;
         w_addr  = AW'(int'(n_q) * CHUNKS + int'(c_q));
      end
      if (state_q == ISSUE) begin
         mac_input_ready = 1'b1;
         mac_in          = act_q[int'(c_q) * VEC_W +: VEC_W];
         mac_w           = w_data;
      end
   end

   // Counters, latched activations, sticky error and output index.
   always_comb begin
      n_d   = n_q;
      c_d   = c_q;
      act_d = act_q;
      err_d = err_q;
      idx_d = idx_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               act_d = act_vec;
               n_d   = '0;
               c_d   = '0;
               err_d = 1'b0;
            end
         end
         ACC: begin
            if (!mac_result_ready) err_d = 1'b1;
            if (last_chunk) begin
               idx_d = n_q;
            end else begin
               c_d = c_q + 1'b1;
            end
         end
         OUT: begin
            if (out_ready) begin
               c_d = '0;
               if (!last_neuron) n_d = n_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q   <= '0;
         c_q   <= '0;
         act_q <= '0;
         err_q <= 1'b0;
         idx_q <= '0;
      end else begin
         n_q   <= n_d;
         c_q   <= c_d;
         act_q <= act_d;
         err_q <= err_d;
         idx_q <= idx_d;
      end
   end

   assign acc_clear = ((state_q == IDLE) && start) || ((state_q == OUT) && out_ready);
   assign acc_add   = (state_q == ACC) && mac_result_ready;
   assign acc_load  = (state_q == ACC) && last_chunk;

   layer_acc_relu #(
      .ACC_W   (ACC_W),
      .RELU_EN (RELU_EN)
   ) u_acc (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (acc_clear),
      .add_i        (acc_add),
      .load_i       (acc_load),
      .mac_result_i (mac_result),
      .out_data_o   (out_data)
   );

   assign err     = err_q;
   assign out_idx = idx_q;
endmodule

// File: tb/tb_neuron_layer_sched.sv
// Self-checking bench: weight ROM and 2-stage neuron models, a layer-level
// reference model feeding a scoreboard, and a monitor on the output stream.
module tb_neuron_layer_sched;
   localparam int N     = 3;
   localparam int C     = 2;
   localparam bit RELU  = 1'b1;
   localparam int AW    = 3;
   localparam int IW    = 2;
   localparam int ACC_W = 13;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic [20*C-1:0]         act_vec;
   logic                    busy, done, err;
   logic                    w_rd_en;
   logic [AW-1:0]           w_addr;
   logic [19:0]             w_data = '0;
   logic                    mac_input_ready;
   logic [19:0]             mac_in, mac_w;
   logic                    mac_result_ready;
   logic signed [11:0]      mac_result;
   logic                    out_valid;
   logic                    out_ready;
   logic [IW-1:0]           out_idx;
   logic signed [ACC_W-1:0] out_data;

   always #5 clk = ~clk;

   neuron_layer_sched #(.NUM_NEURONS(N), .CHUNKS(C), .RELU_EN(RELU)) dut (
      .clk(clk), .rst(rst), .start(start), .act_vec(act_vec),
      .busy(busy), .done(done), .err(err),
      .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
      .mac_input_ready(mac_input_ready), .mac_in(mac_in), .mac_w(mac_w),
      .mac_result_ready(mac_result_ready), .mac_result(mac_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_data(out_data)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // External weight ROM, one-cycle read latency.
   logic [19:0] wmem [N*C];
   always @(posedge clk) if (w_rd_en) w_data <= wmem[w_addr];

   function automatic int lane_dot(input logic [19:0] a, input logic [19:0] b);
      int s = 0;
      for (int k = 0; k < 4; k++)
         s += int'($signed(a[5*k +: 5])) * int'($signed(b[5*k +: 5]));
      return s;
   endfunction

   // External neuron: products registered, sum presented the next cycle.
   int issue_total = 0;
   int drop_target = -1;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mac_result_ready <= 1'b0;
         mac_result       <= '0;
      end else if (mac_input_ready) begin
         mac_result       <= 12'(lane_dot(mac_in, mac_w));
         mac_result_ready <= (issue_total != drop_target);
         issue_total      <= issue_total + 1;
      end else begin
         mac_result_ready <= 1'b0;
      end
   end

   typedef struct { int idx; int data; } exp_t;
   exp_t sb[$];

   // Output monitor.
   exp_t                    e;
   bit                      prev_stall = 0;
   logic [IW-1:0]           prev_idx;
   logic signed [ACC_W-1:0] prev_data;
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            check("no_read_in_out", w_rd_en, 0);
            if (prev_stall) begin
               check("stall_idx_stable", out_idx, prev_idx);
               check("stall_data_stable", out_data, prev_data);
            end
            if (out_ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: got idx %0d data %0d expected none", out_idx, out_data);
               end else begin
                  e = sb.pop_front();
                  check("out_idx", out_idx, e.idx);
                  check("out_data", out_data, e.data);
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_idx   = out_idx;
         prev_data  = out_data;
      end else begin
         prev_stall = 0;
      end
   end

   int act_a [C][4];
   int w_a   [N*C][4];

   // mode 0 random, 1 all -16 (max positive sum), 2 acts 1 / weights negative.
   task automatic prep_layer(input int mode, input int drop_at);
      exp_t x;
      for (int c = 0; c < C; c++)
         for (int k = 0; k < 4; k++)
            act_a[c][k] = (mode == 0) ? int'($urandom_range(0, 31)) - 16 : (mode == 1) ? -16 : 1;
      for (int a = 0; a < N*C; a++)
         for (int k = 0; k < 4; k++)
            w_a[a][k] = (mode == 0) ? int'($urandom_range(0, 31)) - 16 :
                        (mode == 1) ? -16 : -int'($urandom_range(1, 16));
      for (int a = 0; a < N*C; a++)
         for (int k = 0; k < 4; k++)
            wmem[a][5*k +: 5] = 5'(w_a[a][k]);
      for (int n = 0; n < N; n++) begin
         int s = 0;
         for (int c = 0; c < C; c++)
            if (n*C + c != drop_at)
               for (int k = 0; k < 4; k++) s += act_a[c][k] * w_a[n*C + c][k];
         if (RELU && s < 0) s = 0;
         x.idx  = n;
         x.data = s;
         sb.push_back(x);
      end
      drop_target = (drop_at >= 0) ? issue_total + drop_at : -1;
      for (int c = 0; c < C; c++)
         for (int k = 0; k < 4; k++)
            act_vec[20*c + 5*k +: 5] = 5'(act_a[c][k]);
      start = 1'b1;
   endtask

   task automatic run_layer(input int mode, input int drop_at, input int stall_n,
                            input int stall_len, input bit poke, input bit rand_ready);
      int  cyc = 0;
      int  stalls = 0;
      int  stall_left = stall_len;
      bit  got_done = 0;
      prep_layer(mode, drop_at);
      while (!got_done && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            check("busy_after_start", busy, 1);
            check("err_cleared_by_start", err, 0);
         end
         if (poke && cyc == 5) begin
            start   = 1'b1;
            act_vec = {$urandom, $urandom};
         end
         if (poke && cyc == 6) start = 1'b0;
         if (out_valid && int'(out_idx) == stall_n && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 2) != 0);
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && !out_ready) stalls++;
         if (done) got_done = 1;
      end
      check("done_seen", got_done, 1);
      check("layer_latency", cyc, N*(3*C + 1) + 1 + stalls);
      check("err_at_done", err, (drop_at >= 0) ? 1 : 0);
      check("all_outputs_seen", sb.size(), 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_w_rd_en"}, w_rd_en, 0);
      check({tag, "_w_addr"}, w_addr, 0);
      check({tag, "_mac_input_ready"}, mac_input_ready, 0);
      check({tag, "_mac_in"}, mac_in, 0);
      check({tag, "_mac_w"}, mac_w, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_idx"}, out_idx, 0);
      check({tag, "_out_data"}, out_data, 0);
   endtask

   task automatic reset_mid_layer();
      int base = issue_total;
      int cyc  = 0;
      prep_layer(0, -1);
      while (!(mac_input_ready && issue_total == base + C) && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
      end
      check("reach_issue_n1", cyc < 100, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      sb.delete();
      drop_target = -1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         check("no_done_after_rst", done, 0);
         check("no_busy_after_rst", busy, 0);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      act_vec   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("idle");
      out_ready = 1'b1;

      run_layer(0, -1, -1, 0, 0, 0);   // basic random layer
      run_layer(1, -1, -1, 0, 0, 0);   // full-scale positive sum, 2048
      run_layer(2, -1, -1, 0, 0, 0);   // all negative -> ReLU zero
      run_layer(0, -1, 1, 5, 0, 0);    // 5-cycle backpressure on neuron 1
      run_layer(0, -1, -1, 0, 1, 0);   // start and act_vec poked mid-layer
      run_layer(0, 3, -1, 0, 0, 0);    // dropped result_ready -> sticky err
      run_layer(0, -1, -1, 0, 0, 0);   // next start clears err
      reset_mid_layer();
      run_layer(0, -1, -1, 0, 0, 0);   // fresh layer after reset
      for (int i = 0; i < 8; i++)
         run_layer(0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N*C - 1)) : -1,
                   -1, 0, 1'($urandom_range(0, 1)), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
